sub5bits_serial: RTL



---
 rtl/sub_pkg.sv | 12 +
 rtl/sub5bits_serial_subtractor.sv | 18 +
 rtl/sub5bits_serial.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : sub_pkg

// File: rtl/sub5bits_serial_subtractor.sv
// 1-bit full-subtractor cell, mirror of the adder's full-adder cell.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   bout : borrow out
//   d    : difference bit
module subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic bout,
   output logic d
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : subtractor

// File: rtl/sub5bits_serial.sv
// Bit-serial subtractor: out = A - B - E, LSB first, one bit per clock.
// Optional build macro SUB5_SATURATE_EN: on underflow the result clamps to 0
// (borrow still reports 1); without it the result wraps modulo 2^WIDTH.
// Ports:
//   clk    : rising-edge clock
//   Reset  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   A, B   : minuend / subtrahend, captured on the accepted start edge
//   E      : borrow-in, captured on the accepted start edge
//   stop   : combinational override forcing out/borrow to 0
//   busy   : high in RUN and DONE
//   done   : one-cycle completion pulse
//   out    : held difference
//   borrow : held final borrow-out
module sub5bits_serial
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             E,
   input  logic             stop,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             borrow
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, out_q;
   logic             br, bout_q;
   logic             load_c, step_c, last_c, d_c, br_nxt_c;
   logic [WIDTH-1:0] result_c;

   // Single cell works on the LSB of the shifting operands.
   subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .bout (br_nxt_c),
      .d    (d_c)
   );

   assign last_c   = (cnt == CW'(WIDTH - 1));
   assign result_c = {d_c, res_sr[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      step_c    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_c    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step_c = 1'b1;
            if (last_c) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand/result shift registers, running borrow and held outputs.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         out_q  <= '0;
         bout_q <= 1'b0;
      end else if (load_c) begin
         cnt    <= '0;
         a_sr   <= A;
         b_sr   <= B;
         res_sr <= '0;
         br     <= E;
      end else if (step_c) begin
         cnt    <= cnt + CW'(1);
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= result_c;
         br     <= br_nxt_c;
         if (last_c) begin
`ifdef SUB5_SATURATE_EN
            out_q  <= br_nxt_c ? '0 : result_c;
`else
            out_q  <= result_c;
`endif
            bout_q <= br_nxt_c;
         end
      end
   end

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   // stop masks only the visible result; the held registers are untouched.
   assign out    = stop ? '0 : out_q;
   assign borrow = ~stop & bout_q;

endmodule : sub5bits_serial
